// File: rtl/dot_line_renderer.sv
// dot_line_renderer: holds processor-written dot X/Y tables and, once per
// video line, scans every dot to build a 1-bit-per-pixel buffer for the
// next line. The pixel path then only looks up that buffer.
// Optional feature macro: DOT_HIT_COUNT_EN (per-line matched-dot counter on
// line_hits; when undefined line_hits is tied to 0).
module dot_line_renderer #(
    parameter int NUM_DOTS = 450,
    parameter int ID_W     = 9,
    parameter int H_ACTIVE = 640,
    parameter int DOT_SIZE = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic            wr_is_y,
    input  logic [ID_W-1:0] wr_id,
    input  logic [31:0]     wr_data,
    input  logic            line_start,
    input  logic [9:0]      line_y,
    input  logic [9:0]      pix_x,
    output logic            pix_hit,
    output logic            busy,
    output logic            scan_done,
    output logic [ID_W-1:0] line_hits
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [ID_W-1:0]     LAST_IDX = ID_W'(NUM_DOTS);
    localparam logic [H_ACTIVE-1:0] DOT_ONES = {{(H_ACTIVE-DOT_SIZE){1'b0}}, {DOT_SIZE{1'b1}}};

    state_t state, state_nxt;

    logic [9:0]                x_tab [NUM_DOTS];
    logic [9:0]                y_tab [NUM_DOTS];
    logic [NUM_DOTS-1:0]       valid_x, valid_y;
    logic [1:0][H_ACTIVE-1:0]  bufs;
    logic                      sel;
    logic [ID_W-1:0]           idx;
    logic [9:0]                ly_p0;
    logic [9:0]                rd_x_p1, rd_y_p1;
    logic                      live_p1, vld_p1;
    logic                      issue, scan_end, hit_p1, eval_hit;
    logic [H_ACTIVE-1:0]       dot_mask, disp_buf;
    logic                      unused_wr_bits;

    assign unused_wr_bits = ^wr_data[31:10];

    assign busy     = (state == SCAN);
    assign issue    = (state == SCAN) && (idx != LAST_IDX);
    assign scan_end = (state == SCAN) && (idx == LAST_IDX);
    assign disp_buf = bufs[sel];

    // Y range is checked in 11 bits so Y+DOT_SIZE near 1023 cannot wrap.
    assign hit_p1   = live_p1 &&
                      ({1'b0, rd_y_p1} <= {1'b0, ly_p0}) &&
                      ({1'b0, ly_p0} < ({1'b0, rd_y_p1} + 11'(DOT_SIZE)));
    assign eval_hit = vld_p1 && hit_p1 && !line_start;
    // Bits shifted past H_ACTIVE-1 fall off, which clips the dot at the edge.
    assign dot_mask = DOT_ONES << rd_x_p1;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: line_start always (re)starts a scan, even mid-scan.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (line_start) state_nxt = SCAN;
            SCAN: begin
                if (line_start)    state_nxt = SCAN;
                else if (scan_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coordinate tables: no reset, contents are masked by the valid bits.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_id < LAST_IDX)) begin
            if (wr_is_y) y_tab[wr_id] <= wr_data[9:0];
            else         x_tab[wr_id] <= wr_data[9:0];
        end
    end

    // Valid bits: a dot becomes live once both its X and Y have been written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_x <= '0;
            valid_y <= '0;
        end else if (wr_en && (wr_id < LAST_IDX)) begin
            if (wr_is_y) valid_y[wr_id] <= 1'b1;
            else         valid_x[wr_id] <= 1'b1;
        end
    end

    // Scan read stage: old table value is seen when a write hits the same entry.
    always_ff @(posedge clock) begin
        if (issue && !line_start) begin
            rd_x_p1 <= x_tab[idx];
            rd_y_p1 <= y_tab[idx];
        end
    end

    // Scan control, buffer swap/clear and evaluate stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bufs      <= '0;
            sel       <= 1'b0;
            idx       <= '0;
            ly_p0     <= '0;
            vld_p1    <= 1'b0;
            live_p1   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (line_start) begin
                sel       <= ~sel;
                bufs[sel] <= '0;
                ly_p0     <= line_y;
                idx       <= '0;
                vld_p1    <= 1'b0;
            end else begin
                if (issue) begin
                    idx     <= idx + ID_W'(1);
                    vld_p1  <= 1'b1;
                    live_p1 <= valid_x[idx] & valid_y[idx];
                end else begin
                    vld_p1  <= 1'b0;
                end
                if (eval_hit) bufs[~sel] <= bufs[~sel] | dot_mask;
                if (scan_end) scan_done <= 1'b1;
            end
        end
    end

    // Pixel lookup into the display buffer, one clock of latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pix_hit <= 1'b0;
        else          pix_hit <= (pix_x < 10'(H_ACTIVE)) ? disp_buf[pix_x] : 1'b0;
    end

`ifdef DOT_HIT_COUNT_EN
    logic [ID_W-1:0] hit_cnt;

    function automatic logic [ID_W-1:0] sat_inc(input logic [ID_W-1:0] v);
        return (&v) ? v : v + ID_W'(1);
    endfunction

    // Matched-dot counter; published only when a scan completes, not on abort.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt   <= '0;
            line_hits <= '0;
        end else if (line_start) begin
            hit_cnt <= '0;
        end else begin
            if (eval_hit) hit_cnt <= sat_inc(hit_cnt);
            if (scan_end) line_hits <= eval_hit ? sat_inc(hit_cnt) : hit_cnt;
        end
    end
`else
    assign line_hits = '0;
`endif

endmodule

// File: tb/tb_dot_line_renderer.sv
// Bench for dot_line_renderer: directed and random scenarios checked against
// a dot-list reference model (a pixel is lit if any live dot's square covers it).
`timescale 1ns/1ps
module tb_dot_line_renderer;
    localparam int NUM_DOTS = 450;
    localparam int ID_W     = 9;
    localparam int H_ACTIVE = 640;
    localparam int DOT_SIZE = 4;
    localparam int SWEEP    = 660;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_en = 1'b0;
    logic            wr_is_y = 1'b0;
    logic [ID_W-1:0] wr_id = '0;
    logic [31:0]     wr_data = '0;
    logic            line_start = 1'b0;
    logic [9:0]      line_y = '0;
    logic [9:0]      pix_x = '0;
    logic            pix_hit, busy, scan_done;
    logic [ID_W-1:0] line_hits;

    int n_tests = 0;
    int n_fail  = 0;

    int mx [NUM_DOTS];
    int my [NUM_DOTS];
    bit vx [NUM_DOTS];
    bit vy [NUM_DOTS];
    bit obs [SWEEP];
    bit exp_px [SWEEP];
    int exp_hits;
    int done_lat;
    bit done_to;
    int obs_hits;

    always #5 clock = ~clock;

    dot_line_renderer #(.NUM_DOTS(NUM_DOTS), .ID_W(ID_W), .H_ACTIVE(H_ACTIVE), .DOT_SIZE(DOT_SIZE)) dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_is_y(wr_is_y), .wr_id(wr_id),
        .wr_data(wr_data), .line_start(line_start), .line_y(line_y), .pix_x(pix_x),
        .pix_hit(pix_hit), .busy(busy), .scan_done(scan_done), .line_hits(line_hits)
    );

    function automatic bit model_hit(int ly, int px);
        if (px >= H_ACTIVE) return 1'b0;
        for (int i = 0; i < NUM_DOTS; i++)
            if (vx[i] && vy[i] && my[i] <= ly && ly < my[i] + DOT_SIZE && mx[i] <= px && px < mx[i] + DOT_SIZE)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_count(int ly);
        int c = 0;
        for (int i = 0; i < NUM_DOTS; i++)
            if (vx[i] && vy[i] && my[i] <= ly && ly < my[i] + DOT_SIZE) c++;
        return c;
    endfunction

    task automatic fill_exp(int ly);
        for (int p = 0; p < SWEEP; p++) exp_px[p] = model_hit(ly, p);
`ifdef DOT_HIT_COUNT_EN
        exp_hits = model_count(ly);
`else
        exp_hits = 0;
`endif
    endtask

    task automatic wr(int id, bit isy, int data);
        @(negedge clock);
        wr_en = 1'b1; wr_is_y = isy; wr_id = ID_W'(id); wr_data = 32'(data);
        @(negedge clock);
        wr_en = 1'b0;
        if (id < NUM_DOTS) begin
            if (isy) begin my[id] = data & 1023; vy[id] = 1'b1; end
            else     begin mx[id] = data & 1023; vx[id] = 1'b1; end
        end
    endtask

    task automatic pulse_line(int ly);
        @(negedge clock);
        line_start = 1'b1; line_y = 10'(ly);
        @(negedge clock);
        line_start = 1'b0;
    endtask

    task automatic wait_done();
        done_lat = 0; done_to = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clock);
            if (scan_done) begin done_lat = k; done_to = 1'b0; obs_hits = int'(line_hits); break; end
        end
    endtask

    task automatic sweep();
        for (int p = 0; p <= SWEEP; p++) begin
            @(negedge clock);
            if (p > 0) obs[p-1] = pix_hit;
            if (p < SWEEP) pix_x = 10'(p);
        end
    endtask

    // Scan line ly, let it complete, make it the display buffer, read it out.
    task automatic build_line(int ly);
        fill_exp(ly);
        pulse_line(ly);
        wait_done();
        pulse_line(0);
        sweep();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_tests++; if (busy !== 1'b0 || pix_hit !== 1'b0 || scan_done !== 1'b0 || line_hits !== '0) begin
            n_fail++; $display("FAIL reset_hold busy=%b pix_hit=%b scan_done=%b line_hits=%0d want all 0", busy, pix_hit, scan_done, line_hits);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_tests++; if (busy !== 1'b0 || pix_hit !== 1'b0 || scan_done !== 1'b0 || line_hits !== '0) begin
            n_fail++; $display("FAIL reset_release busy=%b pix_hit=%b scan_done=%b line_hits=%0d want all 0", busy, pix_hit, scan_done, line_hits);
        end
    endtask

    task automatic test_single_dot();
        wr(5, 1'b0, 100);
        wr(5, 1'b1, 200);
        build_line(202);
        n_tests++; if (done_to || done_lat != NUM_DOTS + 1) begin
            n_fail++; $display("FAIL single_latency got %0d timeout=%b want %0d", done_lat, done_to, NUM_DOTS + 1);
        end
`ifdef DOT_HIT_COUNT_EN
        n_tests++; if (obs_hits != 1) begin n_fail++; $display("FAIL single_hits got %0d want 1", obs_hits); end
`else
        n_tests++; if (obs_hits != 0) begin n_fail++; $display("FAIL single_hits got %0d want 0", obs_hits); end
`endif
        for (int p = 99; p <= 104; p++) begin
            n_tests++; if (obs[p] !== ((p >= 100 && p <= 103) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL single_px px=%0d got %b", p, obs[p]);
            end
        end
        for (int p = 0; p < SWEEP; p++) begin
            n_tests++; if (obs[p] !== exp_px[p]) begin n_fail++; $display("FAIL single_model px=%0d got %b want %b", p, obs[p], exp_px[p]); end
        end
    endtask

    task automatic test_valid_clip();
        wr(7, 1'b0, 50);
        build_line(0);
        for (int p = 0; p < SWEEP; p++) begin
            n_tests++; if (obs[p] !== 1'b0) begin n_fail++; $display("FAIL valid_gate px=%0d got %b want 0", p, obs[p]); end
        end
        wr(3, 1'b0, 638);
        wr(3, 1'b1, 10);
        build_line(10);
        n_tests++; if (obs[638] !== 1'b1 || obs[639] !== 1'b1 || obs[0] !== 1'b0 || obs[1] !== 1'b0 || obs[640] !== 1'b0) begin
            n_fail++; $display("FAIL clip got 638=%b 639=%b 0=%b 1=%b 640=%b want 1 1 0 0 0", obs[638], obs[639], obs[0], obs[1], obs[640]);
        end
        for (int p = 0; p < SWEEP; p++) begin
            n_tests++; if (obs[p] !== exp_px[p]) begin n_fail++; $display("FAIL clip_model px=%0d got %b want %b", p, obs[p], exp_px[p]); end
        end
    endtask

    task automatic test_y_range();
        int lys [5] = '{19, 20, 23, 24, 481};
        bit want [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        wr(0, 1'b0, 300);
        wr(0, 1'b1, 20);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) wr(0, 1'b1, 478);
            build_line(lys[i]);
            n_tests++; if (obs[300] !== want[i]) begin
                n_fail++; $display("FAIL y_range ly=%0d got %b want %b", lys[i], obs[300], want[i]);
            end
            n_tests++; if (obs_hits != exp_hits) begin
                n_fail++; $display("FAIL y_range_hits ly=%0d got %0d want %0d", lys[i], obs_hits, exp_hits);
            end
        end
    endtask

    task automatic test_collision();
        wr(449, 1'b0, 500);
        wr(449, 1'b1, 100);
        fill_exp(100);
        pulse_line(100);
        repeat (449) @(negedge clock);
        wr_en = 1'b1; wr_is_y = 1'b0; wr_id = ID_W'(449); wr_data = 32'd520;
        @(negedge clock);
        wr_en = 1'b0;
        mx[449] = 520;
        wait_done();
        n_tests++; if (done_to || done_lat != 1) begin
            n_fail++; $display("FAIL collide_latency got %0d timeout=%b want 1", done_lat, done_to);
        end
        pulse_line(0);
        sweep();
        n_tests++; if (obs[500] !== 1'b1 || obs[520] !== 1'b0) begin
            n_fail++; $display("FAIL collide_old got 500=%b 520=%b want 1 0", obs[500], obs[520]);
        end
        for (int p = 0; p < SWEEP; p++) begin
            n_tests++; if (obs[p] !== exp_px[p]) begin n_fail++; $display("FAIL collide_model px=%0d got %b want %b", p, obs[p], exp_px[p]); end
        end
        build_line(100);
        n_tests++; if (obs[500] !== 1'b0 || obs[520] !== 1'b1) begin
            n_fail++; $display("FAIL collide_new got 500=%b 520=%b want 0 1", obs[500], obs[520]);
        end
    endtask

    task automatic test_bad_id();
        wr(450, 1'b0, 10);
        wr(450, 1'b1, 30);
        build_line(30);
        n_tests++; if (obs[10] !== 1'b0) begin n_fail++; $display("FAIL bad_id px10 got %b want 0", obs[10]); end
        for (int p = 0; p < SWEEP; p++) begin
            n_tests++; if (obs[p] !== exp_px[p]) begin n_fail++; $display("FAIL bad_id_model px=%0d got %b want %b", p, obs[p], exp_px[p]); end
        end
    endtask

    task automatic test_restart();
        int early = 0;
        pulse_line(200);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (scan_done || !busy) early++;
        end
        n_tests++; if (early != 0) begin n_fail++; $display("FAIL restart_first_busy got %0d bad cycles want 0", early); end
        fill_exp(202);
        pulse_line(202);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
        wait_done();
        n_tests++; if (done_to || done_lat != NUM_DOTS + 1) begin
            n_fail++; $display("FAIL restart_latency got %0d timeout=%b want %0d", done_lat, done_to, NUM_DOTS + 1);
        end
        n_tests++; if (obs_hits != exp_hits) begin n_fail++; $display("FAIL restart_hits got %0d want %0d", obs_hits, exp_hits); end
        pulse_line(0);
        sweep();
        for (int p = 0; p < SWEEP; p++) begin
            n_tests++; if (obs[p] !== exp_px[p]) begin n_fail++; $display("FAIL restart_model px=%0d got %b want %b", p, obs[p], exp_px[p]); end
        end
    endtask

    task automatic test_reset_mid();
        wr(9, 1'b0, 200);
        wr(9, 1'b1, 300);
        build_line(300);
        @(negedge clock); pix_x = 10'd200;
        @(negedge clock);
        n_tests++; if (pix_hit !== 1'b1) begin n_fail++; $display("FAIL reset_pre_hit got %b want 1", pix_hit); end
        pulse_line(300);
        repeat (50) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || pix_hit !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid busy=%b pix_hit=%b want 0 0", busy, pix_hit);
        end
        for (int i = 0; i < NUM_DOTS; i++) begin vx[i] = 1'b0; vy[i] = 1'b0; end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        build_line(300);
        n_tests++; if (obs[200] !== 1'b0 || obs_hits != 0) begin
            n_fail++; $display("FAIL reset_invalid px200=%b hits=%0d want 0 0", obs[200], obs_hits);
        end
        for (int p = 0; p < SWEEP; p++) begin
            n_tests++; if (obs[p] !== exp_px[p]) begin n_fail++; $display("FAIL reset_model px=%0d got %b want %b", p, obs[p], exp_px[p]); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int pick = 0;
            int ly;
            for (int d = 0; d < 30; d++) begin
                int id = int'($urandom_range(NUM_DOTS - 1));
                wr(id, 1'b0, int'($urandom_range(659)));
                wr(id, 1'b1, int'($urandom_range(479)));
                pick = id;
            end
            ly = my[pick] + int'($urandom_range(DOT_SIZE - 1));
            build_line(ly);
            n_tests++; if (done_to || done_lat != NUM_DOTS + 1) begin
                n_fail++; $display("FAIL rand_latency r=%0d got %0d want %0d", r, done_lat, NUM_DOTS + 1);
            end
            n_tests++; if (obs_hits != exp_hits) begin n_fail++; $display("FAIL rand_hits r=%0d got %0d want %0d", r, obs_hits, exp_hits); end
            for (int p = 0; p < SWEEP; p++) begin
                n_tests++; if (obs[p] !== exp_px[p]) begin
                    n_fail++; $display("FAIL rand_model r=%0d ly=%0d px=%0d got %b want %b", r, ly, p, obs[p], exp_px[p]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_dot();
        test_valid_clip();
        test_y_range();
        test_collision();
        test_bad_id();
        test_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
